// File: rtl/wb_arbiter_2m_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int unsigned WB_DW               = 32;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;
    localparam int unsigned DEF_TIMEOUT         = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef logic mst_idx_t;

    // Single requester wins outright; a tie goes to the master that did not win last.
    function automatic mst_idx_t rr_pick(input logic [1:0] cyc, input mst_idx_t last);
        return (cyc == 2'b11) ? ~last : mst_idx_t'(cyc[1]);
    endfunction

endpackage

// File: rtl/wb_arbiter_2m_ctr.sv
// Outstanding-strobe counter with an ack-free timeout watchdog.
module wb_outstanding_ctr
    import wb_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned TIMEOUT         = DEF_TIMEOUT,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned TMO_W          = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic             ack,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             timeout
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    // A timeout flushes the in-flight count so a dead slave cannot wedge the owner.
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (clear || timeout) begin
            cnt_d = '0;
            tmo_d = '0;
        end else begin
            if (accept && !ack) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (ack && !accept) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (ack || (cnt_q == '0)) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    assign count   = cnt_q;
    assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign timeout = (tmo_q == TMO_W'(TIMEOUT));

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter; the owner keeps the bus until it drops cyc.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned TIMEOUT         = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            m_wb_cyc,
    input  logic [1:0]            m_wb_stb,
    input  logic [1:0]            m_wb_we,
    input  logic [1:0][WB_DW-1:0] m_wb_addr,
    input  logic [1:0][WB_DW-1:0] m_wb_wdata,
    output logic [1:0]            m_wb_ack,
    output logic [1:0]            m_wb_stall,
    output logic [1:0]            m_wb_err,
    output logic [WB_DW-1:0]      m_wb_rdata,
    output logic                  s_wb_cyc,
    output logic                  s_wb_stb,
    output logic                  s_wb_we,
    output logic [WB_DW-1:0]      s_wb_addr,
    output logic [WB_DW-1:0]      s_wb_wdata,
    input  logic                  s_wb_ack,
    input  logic                  s_wb_stall,
    input  logic [WB_DW-1:0]      s_wb_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e       state_q, state_d;
    mst_idx_t         owner_q, owner_d;
    mst_idx_t         last_q, last_d;
    logic [CNT_W-1:0] ctr_count;
    logic             ctr_full;
    logic             ctr_timeout;
    logic             ctr_clear;
    logic             fwd_ack;
    logic             accept;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Grant, routing and abort; slave-side controls are only live while the owner holds cyc.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        s_wb_cyc   = 1'b0;
        s_wb_stb   = 1'b0;
        s_wb_we    = 1'b0;
        s_wb_addr  = '0;
        s_wb_wdata = '0;
        m_wb_stall = 2'b11;
        m_wb_ack   = 2'b00;
        m_wb_err   = 2'b00;
        fwd_ack    = 1'b0;
        ctr_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|m_wb_cyc) begin
                    state_d = ST_BUSY;
                    owner_d = rr_pick(m_wb_cyc, last_q);
                    last_d  = owner_d;
                end
            end
            ST_BUSY: begin
                if (!m_wb_cyc[owner_q]) begin
                    state_d   = ST_IDLE;
                    ctr_clear = 1'b1;
                end else begin
                    s_wb_cyc            = 1'b1;
                    s_wb_stb            = m_wb_stb[owner_q] & ~ctr_full;
                    s_wb_we             = m_wb_we[owner_q];
                    s_wb_addr           = m_wb_addr[owner_q];
                    s_wb_wdata          = m_wb_wdata[owner_q];
                    m_wb_stall[owner_q] = s_wb_stall | ctr_full;
                    fwd_ack             = s_wb_ack & (ctr_count != '0);
                    m_wb_ack[owner_q]   = fwd_ack;
                    m_wb_err[owner_q]   = ctr_timeout;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept     = s_wb_stb & ~s_wb_stall;
    assign m_wb_rdata = s_wb_rdata;

    wb_outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TIMEOUT         (TIMEOUT)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (resetn),
        .accept  (accept),
        .ack     (fwd_ack),
        .clear   (ctr_clear),
        .count   (ctr_count),
        .full    (ctr_full),
        .timeout (ctr_timeout)
    );

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: arbitration, flow control, read data, timeout, abort and reset.
module tb_wb_arbiter_2m;

    localparam int unsigned MAXO = 4;
    localparam int unsigned TMO  = 8;

    logic             clk;
    logic             resetn;
    logic [1:0]       m_cyc, m_stb, m_we;
    logic [1:0][31:0] m_addr, m_wdata;
    logic [1:0]       m_ack, m_stall, m_err;
    logic [31:0]      m_rdata;
    logic             s_cyc, s_stb, s_we;
    logic [31:0]      s_addr, s_wdata;
    logic             s_ack, s_stall;
    logic [31:0]      s_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] rd_tbl [3] = '{32'h0010_0093, 32'h0020_8113, 32'h0030_a193};

    wb_arbiter_2m #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m_wb_cyc   (m_cyc),
        .m_wb_stb   (m_stb),
        .m_wb_we    (m_we),
        .m_wb_addr  (m_addr),
        .m_wb_wdata (m_wdata),
        .m_wb_ack   (m_ack),
        .m_wb_stall (m_stall),
        .m_wb_err   (m_err),
        .m_wb_rdata (m_rdata),
        .s_wb_cyc   (s_cyc),
        .s_wb_stb   (s_stb),
        .s_wb_we    (s_we),
        .s_wb_addr  (s_addr),
        .s_wb_wdata (s_wdata),
        .s_wb_ack   (s_ack),
        .s_wb_stall (s_stall),
        .s_wb_rdata (s_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn  = 1'b0;
        m_cyc   = 2'b00;
        m_stb   = 2'b00;
        m_we    = 2'b00;
        m_addr  = '0;
        m_wdata = '0;
        s_ack   = 1'b0;
        s_stall = 1'b0;
        s_rdata = '0;

        // Reset values
        tick(); tick(); settle();
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_stall", 32'(m_stall), 32'd3);
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);

        // Simultaneous request out of reset: master 0 first, then master 1
        tick();
        resetn    = 1'b1;
        m_cyc     = 2'b11;
        m_addr[0] = 32'h0000_1000;
        m_addr[1] = 32'h0000_2000;
        settle();
        chk("idle_s_cyc", 32'(s_cyc), 32'd0);
        chk("idle_stall", 32'(m_stall), 32'd3);
        tick(); settle();
        chk("grant0_cyc", 32'(s_cyc), 32'd1);
        chk("grant0_stall", 32'(m_stall), 32'd2);
        chk("grant0_addr", s_addr, 32'h0000_1000);
        m_cyc = 2'b10;
        settle();
        chk("drop0_cyc", 32'(s_cyc), 32'd0);
        tick(); settle();
        chk("idle2_cyc", 32'(s_cyc), 32'd0);
        chk("idle2_stall", 32'(m_stall), 32'd3);
        tick(); settle();
        chk("grant1_cyc", 32'(s_cyc), 32'd1);
        chk("grant1_stall", 32'(m_stall), 32'd1);
        chk("grant1_addr", s_addr, 32'h0000_2000);

        // Six back-to-back writes from master 1, slave never acks
        m_stb      = 2'b10;
        m_we       = 2'b10;
        m_wdata[1] = 32'hcafe_0000;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_stb", 32'(s_stb), 32'd1);
            chk("b2b_stall", 32'(m_stall), 32'd1);
            chk("b2b_wdata", s_wdata, 32'hcafe_0000 + 32'(i));
            tick();
            m_wdata[1] = 32'hcafe_0000 + 32'(i + 1);
            settle();
        end
        for (int i = 0; i < 2; i++) begin
            chk("held_stall", 32'(m_stall), 32'd3);
            chk("held_stb", 32'(s_stb), 32'd0);
            chk("held_we", 32'(s_we), 32'd1);
            tick(); settle();
        end
        m_cyc = 2'b00;
        m_stb = 2'b00;
        m_we  = 2'b00;
        settle();
        chk("abort1_cyc", 32'(s_cyc), 32'd0);
        tick();

        // Reads from master 0, slave acks three cycles after each strobe
        m_cyc = 2'b01;
        tick(); settle();
        chk("grantC_stall", 32'(m_stall), 32'd2);
        for (int i = 0; i < 3; i++) begin
            m_addr[0] = 32'h0000_0100 + 32'(i * 4);
            m_stb     = 2'b01;
            if (i == 0) begin
                s_stall = 1'b1;
                settle();
                chk("stall_route", 32'(m_stall), 32'd3);
                s_stall = 1'b0;
            end
            settle();
            chk("rd_stb", 32'(s_stb), 32'd1);
            chk("rd_addr", s_addr, 32'h0000_0100 + 32'(i * 4));
            exp_q.push_back(rd_tbl[i]);
            tick();
            m_stb = 2'b00;
            settle();
            tick(); tick();
            s_ack   = 1'b1;
            s_rdata = rd_tbl[i];
            settle();
            chk("rd_ack", 32'(m_ack), 32'd1);
            if (m_ack[0] && (exp_q.size() != 0)) begin
                exp_v = exp_q.pop_front();
                chk("rd_data", m_rdata, exp_v);
            end
            tick();
            s_ack   = 1'b0;
            s_rdata = '0;
            settle();
        end
        s_ack = 1'b1;
        settle();
        chk("spur_ack", 32'(m_ack), 32'd0);
        tick();
        s_ack = 1'b0;
        settle();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // One strobe, no ack: error pulse eight cycles after the accept
        m_addr[0] = 32'h0000_0200;
        m_stb     = 2'b01;
        settle();
        chk("tmo_stb", 32'(s_stb), 32'd1);
        tick();
        m_stb = 2'b00;
        settle();
        for (int k = 1; k <= 8; k++) begin
            chk("tmo_quiet", 32'(m_err), 32'd0);
            tick(); settle();
        end
        chk("tmo_err", 32'(m_err), 32'd1);
        chk("tmo_busy", 32'(s_cyc), 32'd1);
        tick(); settle();
        chk("tmo_pulse", 32'(m_err), 32'd0);
        s_ack = 1'b1;
        settle();
        chk("tmo_cleared", 32'(m_ack), 32'd0);
        tick();
        s_ack = 1'b0;
        settle();

        // Owner drops cyc with two outstanding, then a late ack
        m_addr[0] = 32'h0000_0300;
        m_stb     = 2'b01;
        settle();
        tick();
        m_addr[0] = 32'h0000_0304;
        settle();
        tick();
        m_stb = 2'b00;
        m_cyc = 2'b00;
        settle();
        chk("abort_same", 32'(s_cyc), 32'd0);
        tick();
        s_ack = 1'b1;
        settle();
        chk("abort_next", 32'(s_cyc), 32'd0);
        chk("late_ack", 32'(m_ack), 32'd0);
        tick();
        s_ack = 1'b0;
        settle();

        // Reset while master 1 has three outstanding
        m_cyc     = 2'b10;
        m_addr[1] = 32'h0000_0400;
        tick(); settle();
        chk("f_grant", 32'(m_stall), 32'd1);
        m_stb = 2'b10;
        settle();
        tick(); tick(); tick();
        m_stb = 2'b00;
        settle();
        chk("f_busy", 32'(s_cyc), 32'd1);
        resetn = 1'b0;
        m_cyc  = 2'b11;
        s_ack  = 1'b1;
        settle();
        chk("mid_rst_cyc", 32'(s_cyc), 32'd0);
        chk("mid_rst_stb", 32'(s_stb), 32'd0);
        chk("mid_rst_stall", 32'(m_stall), 32'd3);
        chk("mid_rst_ack", 32'(m_ack), 32'd0);
        chk("mid_rst_err", 32'(m_err), 32'd0);
        tick(); tick();
        resetn = 1'b1;
        s_ack  = 1'b0;
        settle();
        chk("rel_idle", 32'(s_cyc), 32'd0);
        tick(); settle();
        chk("rel_grant", 32'(m_stall), 32'd2);
        chk("rel_addr", s_addr, 32'h0000_0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
